gpio_bank: RTL

//  Parametrised GPIO bank: N input channels with 2-FF synchronisers, per-channel debounce and sticky

---
 rtl/gpio_bank_pkg.sv | 13 +
 rtl/gpio_bank_if.sv | 22 ++
 rtl/gpio_debounce.sv | 44 ++++
 rtl/gpio_bank.sv | 96 +++++++++
 4 files changed

// File: rtl/gpio_bank_pkg.sv
// Shared definitions for the GPIO bank: register-port data width and the register address map.
package gpio_bank_pkg;

  localparam int unsigned REG_DATA_W = 32;

  typedef logic [1:0] reg_addr_t;

  localparam reg_addr_t GPIO_ADDR_IN   = 2'd0;
  localparam reg_addr_t GPIO_ADDR_OUT  = 2'd1;
  localparam reg_addr_t GPIO_ADDR_EVT  = 2'd2;
  localparam reg_addr_t GPIO_ADDR_MASK = 2'd3;

endpackage

// File: rtl/gpio_bank_if.sv
// Single-cycle register port of the GPIO bank: write/read strobes, address, data and read-valid.
interface gpio_bank_if;
  import gpio_bank_pkg::*;

  logic                  reg_wr_en;
  logic                  reg_rd_en;
  reg_addr_t             reg_addr;
  logic [REG_DATA_W-1:0] reg_wdata;
  logic [REG_DATA_W-1:0] reg_rdata;
  logic                  reg_rd_valid;

  modport master (
    output reg_wr_en, reg_rd_en, reg_addr, reg_wdata,
    input  reg_rdata, reg_rd_valid
  );

  modport slave (
    input  reg_wr_en, reg_rd_en, reg_addr, reg_wdata,
    output reg_rdata, reg_rd_valid
  );

endinterface

// File: rtl/gpio_debounce.sv
// One GPIO input channel: 2-FF synchroniser, stability counter, debounced level and a
// one-cycle change pulse registered on the same edge the level updates.
module gpio_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic change
);

  localparam int unsigned          CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      cnt    <= '0;
      level  <= 1'b0;
      change <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pin};
      change <= 1'b0;
      // Counter clears whenever the synchronised value agrees with the level, so any
      // disagreement run shorter than DEBOUNCE_CYCLES is discarded.
      if (sync_q[1] != level) begin
        if (cnt == CNT_LAST) begin
          level  <= sync_q[1];
          cnt    <= '0;
          change <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/gpio_bank.sv
// GPIO bank: debounced inputs with sticky W1C change flags, registered outputs, register port.
// Optional GPIO_IRQ_EN adds the MASK register and a registered level interrupt.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int unsigned        NUM_IN          = 8,
  parameter int unsigned        NUM_OUT         = 8,
  parameter int unsigned        DEBOUNCE_CYCLES = 16,
  parameter logic [NUM_OUT-1:0] OUT_RESET       = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_IN-1:0]  gpio_in,
  output logic [NUM_OUT-1:0] gpio_out,
  gpio_bank_if.slave         bus,
  output logic               irq
);

  logic [NUM_IN-1:0]     level;
  logic [NUM_IN-1:0]     change;
  logic [NUM_IN-1:0]     evt;
  logic [NUM_IN-1:0]     mask;
  logic [NUM_IN-1:0]     w1c;
  logic [REG_DATA_W-1:0] rd_mux;
  logic                  wr_out;
  logic                  wr_evt;
  logic                  unused_wdata;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_in
    gpio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock (clock),
      .reset (reset),
      .pin   (gpio_in[g]),
      .level (level[g]),
      .change(change[g])
    );
  end

  assign wr_out       = bus.reg_wr_en && (bus.reg_addr == GPIO_ADDR_OUT);
  assign wr_evt       = bus.reg_wr_en && (bus.reg_addr == GPIO_ADDR_EVT);
  assign w1c          = wr_evt ? bus.reg_wdata[NUM_IN-1:0] : '0;
  assign unused_wdata = ^bus.reg_wdata;

  // OR-ing change after the clear makes a same-cycle event win over W1C.
  always_ff @(posedge clock) begin
    if (reset) begin
      gpio_out <= OUT_RESET;
      evt      <= '0;
    end else begin
      if (wr_out) gpio_out <= bus.reg_wdata[NUM_OUT-1:0];
      evt <= (evt & ~w1c) | change;
    end
  end

`ifdef GPIO_IRQ_EN
  logic wr_mask;
  assign wr_mask = bus.reg_wr_en && (bus.reg_addr == GPIO_ADDR_MASK);

  always_ff @(posedge clock) begin
    if (reset) begin
      mask <= '0;
      irq  <= 1'b0;
    end else begin
      if (wr_mask) mask <= bus.reg_wdata[NUM_IN-1:0];
      irq <= |(evt & mask);
    end
  end
`else
  assign mask = '0;
  assign irq  = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (bus.reg_addr)
      GPIO_ADDR_IN:   rd_mux[NUM_IN-1:0]  = level;
      GPIO_ADDR_OUT:  rd_mux[NUM_OUT-1:0] = gpio_out;
      GPIO_ADDR_EVT:  rd_mux[NUM_IN-1:0]  = evt;
      GPIO_ADDR_MASK: rd_mux[NUM_IN-1:0]  = mask;
      default:        rd_mux              = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.reg_rdata    <= '0;
      bus.reg_rd_valid <= 1'b0;
    end else begin
      bus.reg_rd_valid <= bus.reg_rd_en;
      if (bus.reg_rd_en) bus.reg_rdata <= rd_mux;
    end
  end

endmodule
